// File: rtl/multdiv_pkg.sv
// Shared types and sizing helpers for the iterative multiplier/divider.
//   state_t  : FSM states (IDLE, MUL, DIV, FIX, DONE)
//   op_t     : latched operation (OP_MUL, OP_DIV)
//   cnt_bits : iteration-counter width for a given operand width
//   CNT_W    : counter width for the default 8-bit build
package multdiv_pkg;

  typedef enum logic [2:0] {
    IDLE,
    MUL,
    DIV,
    FIX,
    DONE
  } state_t;

  typedef enum logic {
    OP_MUL,
    OP_DIV
  } op_t;

  // The counter must be able to hold the value W itself, not just W-1.
  function automatic int cnt_bits(input int w);
    return $clog2(w + 1);
  endfunction

  localparam int DEFAULT_WIDTH = 8;
  localparam int CNT_W         = cnt_bits(DEFAULT_WIDTH);

endpackage

// File: rtl/multdiv_step.sv
// One combinational iteration of the shift-add multiplier / restoring divider.
//   acc        in  W+1  accumulator (MUL: partial product high half + carry,
//                       DIV: partial remainder)
//   shreg      in  W    shift register (MUL: multiplier bits, DIV: dividend
//                       bits shifting out / quotient bits shifting in)
//   mag_b      in  W    operand B magnitude (addend / divisor)
//   op         in  1    operation selector
//   acc_next   out W+1  accumulator after this iteration
//   shreg_next out W    shift register after this iteration
module multdiv_step
  import multdiv_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0]   acc,
  input  logic [WIDTH-1:0] shreg,
  input  logic [WIDTH-1:0] mag_b,
  input  op_t              op,
  output logic [WIDTH:0]   acc_next,
  output logic [WIDTH-1:0] shreg_next
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] diff;

  always_comb begin
    // MUL: the addition keeps its carry in bit W so nothing is lost.
    sum     = {1'b0, acc[WIDTH-1:0]} + {1'b0, mag_b};
    // DIV: bring the next dividend bit into the partial remainder.
    shifted = {acc[WIDTH-1:0], shreg[WIDTH-1]};
    // One extra bit so the sign of the trial subtraction is unambiguous.
    diff    = {1'b0, shifted} - {2'b00, mag_b};

    acc_next   = acc;
    shreg_next = shreg;

    if (op == OP_MUL) begin
      if (shreg[0]) begin
        acc_next   = {1'b0, sum[WIDTH:1]};
        shreg_next = {sum[0], shreg[WIDTH-1:1]};
      end else begin
        acc_next   = {1'b0, acc[WIDTH:1]};
        shreg_next = {acc[0], shreg[WIDTH-1:1]};
      end
    end else begin
      if (diff[WIDTH+1]) begin
        // Trial went negative: restore and shift in a 0 quotient bit.
        acc_next   = shifted;
        shreg_next = {shreg[WIDTH-2:0], 1'b0};
      end else begin
        acc_next   = diff[WIDTH:0];
        shreg_next = {shreg[WIDTH-2:0], 1'b1};
      end
    end
  end

endmodule

// File: rtl/multdiv_seq.sv
// Iterative multiplier/divider: 2W-bit product or W-bit quotient/remainder.
//   clock          in   1   rising-edge clock
//   reset          in   1   synchronous, active-high
//   ctrl_MULT      in   1   start-multiply pulse (wins over ctrl_DIV)
//   ctrl_DIV       in   1   start-divide pulse
//   data_operandA  in   W   multiplicand / dividend
//   data_operandB  in   W   multiplier / divisor
//   data_result    out  2W  MULT: product; DIV: {remainder, quotient}
//   data_exception out  1   divide-by-zero or signed MIN/-1 overflow
//   data_resultRDY out  1   one-cycle result-valid pulse
//   busy           out  1   operation in flight
module multdiv_seq
  import multdiv_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter bit SIGNED = 1'b0
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               ctrl_MULT,
  input  logic               ctrl_DIV,
  input  logic [WIDTH-1:0]   data_operandA,
  input  logic [WIDTH-1:0]   data_operandB,
  output logic [2*WIDTH-1:0] data_result,
  output logic               data_exception,
  output logic               data_resultRDY,
  output logic               busy
);

  localparam int              CW       = cnt_bits(WIDTH);
  localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  state_t               state_reg;
  op_t                  op_reg;
  logic [CW-1:0]        cnt_reg;
  logic [WIDTH:0]       acc_reg;
  logic [WIDTH-1:0]     shreg_reg;
  logic [WIDTH-1:0]     mag_b_reg;
  logic                 neg_a_reg;
  logic                 neg_b_reg;
  logic                 ovf_reg;
  logic [2*WIDTH-1:0]   result_reg;
  logic                 exc_reg;
  logic                 rdy_reg;
  logic                 busy_reg;

  logic                 start;
  op_t                  start_op;
  logic                 neg_a;
  logic                 neg_b;
  logic [WIDTH-1:0]     mag_a;
  logic [WIDTH-1:0]     mag_b;
  logic [WIDTH:0]       acc_next;
  logic [WIDTH-1:0]     shreg_next;
  logic [2*WIDTH-1:0]   fix_result;
  logic                 fix_exc;

  assign start    = ctrl_MULT | ctrl_DIV;
  assign start_op = ctrl_MULT ? OP_MUL : OP_DIV;

  // Magnitudes are unsigned W-bit values, so |MIN| = 2^(W-1) fits exactly.
  always_comb begin
    neg_a = SIGNED && data_operandA[WIDTH-1];
    neg_b = SIGNED && data_operandB[WIDTH-1];
    mag_a = neg_a ? (~data_operandA + 1'b1) : data_operandA;
    mag_b = neg_b ? (~data_operandB + 1'b1) : data_operandB;
  end

  multdiv_step #(.WIDTH(WIDTH)) u_step (
    .acc        (acc_reg),
    .shreg      (shreg_reg),
    .mag_b      (mag_b_reg),
    .op         (op_reg),
    .acc_next   (acc_next),
    .shreg_next (shreg_next)
  );

  // Sign fix-up and exception resolution on the raw unsigned results.
  always_comb begin
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;
    prod       = {acc_reg[WIDTH-1:0], shreg_reg};
    quo        = shreg_reg;
    rem        = acc_reg[WIDTH-1:0];
    fix_result = '0;
    fix_exc    = 1'b0;
    if (op_reg == OP_MUL) begin
      fix_result = (neg_a_reg ^ neg_b_reg) ? (~prod + 1'b1) : prod;
    end else if (mag_b_reg == '0) begin
      fix_exc = 1'b1;
    end else begin
      if (neg_a_reg ^ neg_b_reg) quo = ~quo + 1'b1;
      if (neg_a_reg)             rem = ~rem + 1'b1;
      // MIN / -1 naturally yields quotient MIN and remainder 0.
      fix_result = {rem, quo};
      fix_exc    = ovf_reg;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg  <= IDLE;
      op_reg     <= OP_MUL;
      cnt_reg    <= '0;
      acc_reg    <= '0;
      shreg_reg  <= '0;
      mag_b_reg  <= '0;
      neg_a_reg  <= 1'b0;
      neg_b_reg  <= 1'b0;
      ovf_reg    <= 1'b0;
      result_reg <= '0;
      exc_reg    <= 1'b0;
      rdy_reg    <= 1'b0;
      busy_reg   <= 1'b0;
    end else if (start) begin
      // A start in any state (re)launches an operation; any op in flight is dropped.
      state_reg  <= (start_op == OP_MUL) ? MUL : DIV;
      op_reg     <= start_op;
      cnt_reg    <= '0;
      acc_reg    <= '0;
      shreg_reg  <= mag_a;
      mag_b_reg  <= mag_b;
      neg_a_reg  <= neg_a;
      neg_b_reg  <= neg_b;
      ovf_reg    <= SIGNED && (start_op == OP_DIV) &&
                    (data_operandA == MIN_VAL) && (data_operandB == '1);
      result_reg <= '0;
      exc_reg    <= 1'b0;
      rdy_reg    <= 1'b0;
      busy_reg   <= 1'b1;
    end else begin
      case (state_reg)
        MUL, DIV: begin
          // Counter runs 0..W: W iterations, then one hand-off edge into FIX.
          if (cnt_reg == CNT_LAST) begin
            state_reg <= FIX;
          end else begin
            acc_reg   <= acc_next;
            shreg_reg <= shreg_next;
            cnt_reg   <= cnt_reg + 1'b1;
          end
        end
        FIX: begin
          result_reg <= fix_result;
          exc_reg    <= fix_exc;
          rdy_reg    <= 1'b1;
          busy_reg   <= 1'b0;
          state_reg  <= DONE;
        end
        DONE: begin
          rdy_reg   <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          rdy_reg   <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign data_result    = result_reg;
  assign data_exception = exc_reg;
  assign data_resultRDY = rdy_reg;
  assign busy           = busy_reg;

endmodule
